// File: rtl/dec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dec_pkg                                                          |
// | Shared constants and types for the decoder-select arbiter.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dec_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int DEC_NREQ  = 4;
    localparam int DEC_IDX_W = 2;

    typedef logic [DEC_IDX_W-1:0] idx_t;

endpackage : dec_pkg
`default_nettype wire

// File: rtl/dec_sel_arbiter_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick                                                          |
// | Combinational round-robin pick: first set req bit from ptr up.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_pick
    import dec_pkg::*;
(
    input  logic [DEC_NREQ-1:0] req,
    input  idx_t                ptr,
    output logic                found,
    output idx_t                idx
);

    logic [2*DEC_NREQ-1:0] w_dbl;
    logic [DEC_NREQ-1:0]   w_rot;
    idx_t                  w_off;

    // Rotate so that bit 0 of w_rot is the requester at ptr.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: DEC_NREQ];

    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int i = DEC_NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                w_off = DEC_IDX_W'(i);
            end
        end
    end

    assign idx = w_off + ptr;

endmodule : rr_pick
`default_nettype wire

// File: rtl/dec_sel_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dec_sel_arbiter                                                  |
// | Round-robin arbiter with per-grant timeout driving a 2-4 decoder.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dec_sel_arbiter
    import dec_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic            a,
    output logic            b,
    output logic            en,
    output logic            timeout
);

    generate
        if (NREQ != DEC_NREQ) begin : g_nreq_bad
            $error("dec_sel_arbiter: NREQ must be 4");
        end
    endgenerate

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [0:0]       r_state;
    idx_t             r_ptr;
    logic [TMR_W-1:0] r_timer;
    logic             r_a;
    logic             r_b;
    logic             r_en;
    logic             r_timeout;

    logic             w_found;
    idx_t             w_pick;
    idx_t             w_idx;
    logic             w_rel_user;
    logic             w_rel_tmo;

    rr_pick u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick)
    );

    assign w_idx      = {r_a, r_b};
    assign w_rel_user = done || !req[w_idx];
    assign w_rel_tmo  = (TIMEOUT != 0) && (r_timer == TMR_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_timer   <= '0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_en      <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        {r_a, r_b} <= w_pick;
                        r_en       <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_rel_user || w_rel_tmo) begin
                        r_en      <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_ptr     <= w_idx + 2'd1;
                        // A user release on the same edge masks the timeout.
                        r_timeout <= !w_rel_user;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign en      = r_en;
    assign timeout = r_timeout;

endmodule : dec_sel_arbiter
`default_nettype wire

// File: tb/tb_dec_sel_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dec_sel_arbiter                                               |
// | Scoreboard bench: behavioural model plus directed grant checks.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dec_sel_arbiter;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic       a, b, en, timeout;

    dec_sel_arbiter #(.NREQ(4), .TIMEOUT(TO)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .a       (a),
        .b       (b),
        .en      (en),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] idx;
        logic       en;
        logic       to;
    } exp_t;

    exp_t q_exp[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_ptr = 0, m_idx = 0, m_timer = 0;
    bit m_en = 0, m_to = 0;

    int zero_run = 0;
    int last_gap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step();
        bit rel_u, rel_t;
        if (!rst_n) begin
            m_ptr = 0; m_idx = 0; m_timer = 0; m_en = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_en) begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (m_ptr + k) % 4;
                    if (req[j]) begin
                        m_idx = j; m_en = 1; m_timer = 0;
                        break;
                    end
                end
            end else begin
                rel_u = done || !req[m_idx];
                rel_t = (m_timer == TO - 1);
                if (rel_u || rel_t) begin
                    m_en  = 0;
                    m_ptr = (m_idx + 1) % 4;
                    m_to  = !rel_u;
                end else if (m_timer < 15) begin
                    m_timer++;
                end
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        e.idx = m_idx[1:0];
        e.en  = m_en;
        e.to  = m_to;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check("sb_en", en, e.en);
        check("sb_idx", {a, b}, e.idx);
        check("sb_timeout", timeout, e.to);
        if (en !== 1'b1) zero_run++;
        else begin
            if (zero_run > 0) last_gap = zero_run;
            zero_run = 0;
        end
    endtask

    task automatic wait_grant(output int idx);
        bit got;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (en === 1'b1) begin
                got = 1;
                break;
            end
        end
        check("grant_wait", got, 1);
        idx = {a, b};
    endtask

    initial begin
        int idx, hi;

        // Reset held with all requesting
        rst_n = 1'b0; req = 4'b1111; done = 1'b0;
        cycle();
        cycle();
        check("rst_en", en, 0);
        check("rst_ab", {a, b}, 0);
        rst_n = 1'b1;
        wait_grant(idx);
        check("rst_first", idx, 0);
        done = 1'b1; cycle(); done = 1'b0;

        // Rotation 1,2,3,0 with single-cycle gaps
        for (int k = 1; k <= 4; k++) begin
            wait_grant(idx);
            check("rot_idx", idx, k % 4);
            check("rot_gap", last_gap, 1);
            done = 1'b1; cycle(); done = 1'b0;
        end

        // Skip and wrap: get ptr to 3, then 0101 -> 0
        req = 4'b0100;
        wait_grant(idx);
        check("skip_pre", idx, 2);
        done = 1'b1; cycle(); done = 1'b0;
        req = 4'b0101;
        wait_grant(idx);
        check("wrap_idx", idx, 0);
        done = 1'b1; cycle(); done = 1'b0;
        req = 4'b0100;
        wait_grant(idx);
        check("skip_idx", idx, 2);

        // Dropping req[2] ends grant without a timeout pulse
        req = 4'b0010;
        cycle();
        check("drop_en", en, 0);
        check("drop_to", timeout, 0);

        // Timeout: en high exactly TO cycles, pulse on the fall
        wait_grant(idx);
        check("to_idx", idx, 1);
        hi = 1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (en === 1'b1) hi++;
            else break;
        end
        check("to_len", hi, TO);
        check("to_pulse", timeout, 1);
        cycle();
        check("to_regrant_en", en, 1);
        check("to_regrant_idx", {a, b}, 1);
        check("to_pulse_end", timeout, 0);

        // done on the timeout edge: no pulse
        for (int n = 0; n < TO - 1; n++) cycle();
        check("sim_still_en", en, 1);
        done = 1'b1; cycle(); done = 1'b0;
        check("sim_en", en, 0);
        check("sim_to", timeout, 0);

        // Request drop of idx 2
        req = 4'b0100;
        wait_grant(idx);
        check("drop2_idx", idx, 2);
        cycle();
        req = 4'b0000;
        cycle();
        check("drop2_en", en, 0);
        check("drop2_to", timeout, 0);

        // Mid-grant reset returns ptr to 0
        req = 4'b1100;
        wait_grant(idx);
        check("mid_idx", idx, 3);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("mid_rst_en", en, 0);
        rst_n = 1'b1;
        wait_grant(idx);
        check("mid_after_idx", idx, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dec_sel_arbiter
`default_nettype wire

// File: doc/dec_sel_arbiter.md
# dec_sel_arbiter

Round-robin arbiter that sits directly upstream of the 2-to-4 `decoder` and drives its `a`, `b` and `en` inputs. Up to four requesters compete for one shared resource. The arbiter grants one at a time and encodes the winner as a 2-bit index (`a` = MSB, `b` = LSB). The decoder turns that index into one-hot strobes `d0`..`d3`. A per-grant timeout stops any single requester from holding the resource forever.

## Interface
Parameters:
- `NREQ`, 4: number of requesters. Fixed at 4 to match the decoder; any other value is a compile-time error.
- `TIMEOUT`, 8: maximum grant length in cycles. 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  request vector; `req[i]` = requester i wants the resource. Level-sensitive.
- `done`  in  1  the current grantee releases the resource this cycle.
- `a`  out  1  grant index MSB, wired to decoder `a`.
- `b`  out  1  grant index LSB, wired to decoder `b`.
- `en`  out  1  grant valid, wired to decoder `en`.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly ended by the timeout.

## Operation
- **Reset** (`rst_n`=0 at an edge): state=IDLE, `a`=0, `b`=0, `en`=0, `timeout`=0, ptr=0, timer=0.
- **State IDLE** (`en`=0):
  - If any `req` bit is set, pick the first set bit scanning from ptr upward, wrapping 3→0.
  - Register the pick into {`a`,`b`}, set `en`=1, clear timer, go to GRANT.
  - If no `req` bit is set, stay in IDLE; `a`/`b` hold their last values.
- **State GRANT** (`en`=1): {`a`,`b`} stay stable; timer increments every cycle. The grant ends on the first edge where any of these holds:
  - `done`=1;
  - `req[idx]`=0, i.e. the grantee dropped its request;
  - `TIMEOUT`≠0 and timer==`TIMEOUT`-1.
- **On release**: `en`=0, go to IDLE, ptr=idx+1 mod 4. `timeout`=1 for that one cycle only if the timeout was the sole cause.
- **Simultaneous release causes**: `done` or a dropped request takes priority over the timeout, so no pulse is raised.
- **Gap cycle**: IDLE always lasts at least one cycle between grants. `en` never stays high across a change of index, so two decoder outputs are never active in back-to-back cycles without a gap.
- **Width rules**:
  - ptr and the index are 2 bits and wrap naturally.
  - The timer is clog2(`TIMEOUT`+1) bits and saturates; it cannot wrap within a grant.
- **Reset mid-grant**: `en`=0 on the next edge and ptr returns to 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Grant latency: `req` sampled at edge N in IDLE gives `en`=1 and a valid index after edge N.
- Release latency: `done` sampled at edge M gives `en`=0 after edge M.
- Earliest next grant: `en`=1 after edge M+1.
- Maximum grant length with `TIMEOUT`=T: `en` is high for exactly T cycles.
- Worst-case wait for a continuously requesting input: 3×(T+1) cycles.

## Structure
- Shared package `dec_pkg` holds:
  - state encoding: IDLE=1'b0, GRANT=1'b1;
  - `DEC_NREQ`=4;
  - `DEC_IDX_W`=2.
- Sub-module `rr_pick`: purely combinational. Takes `req[3:0]` and `ptr[1:0]` and returns `found` and `idx[1:0]` (rotate, priority-encode, un-rotate).
- Top level holds the FSM, ptr, timer and output registers.

## Test plan
- **Reset**: hold `rst_n`=0 for 2 cycles with `req`=4'b1111 → `a`=`b`=`en`=`timeout`=0 throughout; after release, first grant is idx 0 (`a`=0, `b`=0).
- **Rotation**: `req`=4'b1111, `done` pulsed 1 cycle after each grant → grant sequence 0,1,2,3,0, each grant separated by exactly one `en`=0 cycle; decoder produces `d0`,`d1`,`d2`,`d3`,`d0`.
- **Skip and wrap**: ptr=3 and `req`=4'b0101 → grant idx 0; then `req`=4'b0100 → grant idx 2.
- **Timeout**: `TIMEOUT`=8, `req`=4'b0010 held, `done`=0 → `en` high exactly 8 cycles, `timeout`=1 for one cycle as `en` falls, then idx 1 is granted again after a 1-cycle gap.
- **Simultaneous release**: assert `done` on the same edge the timer reaches 7 → `en` falls, `timeout` stays 0.
- **Request drop and mid-grant reset**: deassert `req[2]` during grant of idx 2 → `en`=0 next cycle with no timeout. Separately, assert `rst_n`=0 mid-grant → `en`=0 next cycle and the next grant searches from ptr=0.
